// File: rtl/i2c_slave.sv
// i2c_slave: I2C target endpoint. Oversamples SCL/SDA on clk, detects
// START / repeated START / STOP, matches a 7-bit address, receives write
// bytes, supplies read bytes and drives SDA open-drain through sda_oe.
// Optional build macro: I2C_SLAVE_GLITCH_FILTER_EN adds a 3-sample
// persistence filter after each synchroniser.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       addr_hit,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK
  } state_e;

  logic [SYNC_STAGES-1:0] sclSync_q, sdaSync_q;
  logic                   sclLine, sdaLine;
  logic                   sclPrev_q, sdaPrev_q;
  logic                   sclRise, sclFall, startDet, stopDet;

  state_e     state_q, state_d;
  logic [2:0] bitCnt_q, bitCnt_d;
  logic       ninth_q, ninth_d;
  logic [6:0] shift_q, shift_d;
  logic [7:0] rxData_q, rxData_d;
  logic       rw_q, rw_d;
  logic       sdaOe_q, sdaOe_d;
  logic       rxValid_q, rxValid_d;
  logic       txReq_q, txReq_d;
  logic       addrHit_q, addrHit_d;
  logic       busy_q, busy_d;

  // Bring the asynchronous bus pins into the clk domain; an idle bus is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclSync_q <= '1;
      sdaSync_q <= '1;
    end else begin
      sclSync_q <= {sclSync_q[SYNC_STAGES-2:0], scl_in};
      sdaSync_q <= {sdaSync_q[SYNC_STAGES-2:0], sda_in};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] sclHist_q, sdaHist_q;
  logic       sclFilt_q, sdaFilt_q;

  // Let a filtered line follow the pin only after three equal samples in a row.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclHist_q <= 2'b11;
      sdaHist_q <= 2'b11;
      sclFilt_q <= 1'b1;
      sdaFilt_q <= 1'b1;
    end else begin
      sclHist_q <= {sclHist_q[0], sclSync_q[SYNC_STAGES-1]};
      sdaHist_q <= {sdaHist_q[0], sdaSync_q[SYNC_STAGES-1]};
      if (sclHist_q == {2{sclSync_q[SYNC_STAGES-1]}}) sclFilt_q <= sclSync_q[SYNC_STAGES-1];
      if (sdaHist_q == {2{sdaSync_q[SYNC_STAGES-1]}}) sdaFilt_q <= sdaSync_q[SYNC_STAGES-1];
    end
  end

  assign sclLine = sclFilt_q;
  assign sdaLine = sdaFilt_q;
`else
  assign sclLine = sclSync_q[SYNC_STAGES-1];
  assign sdaLine = sdaSync_q[SYNC_STAGES-1];
`endif

  // Keep the previous line levels so edges and bus conditions can be seen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclPrev_q <= 1'b1;
      sdaPrev_q <= 1'b1;
    end else begin
      sclPrev_q <= sclLine;
      sdaPrev_q <= sdaLine;
    end
  end

  assign sclRise  =  sclLine & ~sclPrev_q;
  assign sclFall  = ~sclLine &  sclPrev_q;
  assign startDet =  sclLine &  sclPrev_q &  sdaPrev_q & ~sdaLine;
  assign stopDet  =  sclLine &  sclPrev_q & ~sdaPrev_q &  sdaLine;

  // State register and all protocol datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      bitCnt_q  <= 3'd0;
      ninth_q   <= 1'b0;
      shift_q   <= 7'd0;
      rxData_q  <= 8'h00;
      rw_q      <= 1'b0;
      sdaOe_q   <= 1'b0;
      rxValid_q <= 1'b0;
      txReq_q   <= 1'b0;
      addrHit_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitCnt_q  <= bitCnt_d;
      ninth_q   <= ninth_d;
      shift_q   <= shift_d;
      rxData_q  <= rxData_d;
      rw_q      <= rw_d;
      sdaOe_q   <= sdaOe_d;
      rxValid_q <= rxValid_d;
      txReq_q   <= txReq_d;
      addrHit_q <= addrHit_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state logic: bus conditions override every state; otherwise sample
  // on SCL rises and change what we drive on SCL falls. ninth_q marks the
  // second half of an acknowledge slot (or a finished TX byte).
  always_comb begin
    state_d   = state_q;
    bitCnt_d  = bitCnt_q;
    ninth_d   = ninth_q;
    shift_d   = shift_q;
    rxData_d  = rxData_q;
    rw_d      = rw_q;
    sdaOe_d   = sdaOe_q;
    rxValid_d = 1'b0;
    txReq_d   = 1'b0;
    addrHit_d = addrHit_q;
    busy_d    = busy_q;
    if (stopDet) begin
      state_d   = IDLE;
      sdaOe_d   = 1'b0;
      busy_d    = 1'b0;
      addrHit_d = 1'b0;
    end else if (startDet) begin
      state_d   = ADDR;
      bitCnt_d  = 3'd0;
      ninth_d   = 1'b0;
      sdaOe_d   = 1'b0;
      addrHit_d = 1'b0;
      busy_d    = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
        end
        ADDR: begin
          if (sclRise) begin
            shift_d  = {shift_q[5:0], sdaLine};
            bitCnt_d = bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
              if (shift_q == SLAVE_ADDR) begin
                state_d   = ADDR_ACK;
                addrHit_d = 1'b1;
                rw_d      = sdaLine;
                ninth_d   = 1'b0;
              end else begin
                state_d = IDLE;
              end
            end
          end
        end
        ADDR_ACK, RX_ACK: begin
          if (sclFall) begin
            if (!ninth_q) begin
              sdaOe_d = 1'b1;
              ninth_d = 1'b1;
            end else begin
              ninth_d  = 1'b0;
              bitCnt_d = 3'd0;
              if (state_q == ADDR_ACK && rw_q) begin
                shift_d = tx_data[6:0];
                sdaOe_d = ~tx_data[7];
                state_d = TX_BYTE;
              end else begin
                sdaOe_d = 1'b0;
                state_d = RX_BYTE;
              end
            end
          end else if (sclRise && ninth_q && state_q == ADDR_ACK && rw_q) begin
            txReq_d = 1'b1;
          end
        end
        RX_BYTE: begin
          if (sclRise) begin
            shift_d  = {shift_q[5:0], sdaLine};
            bitCnt_d = bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
              rxData_d  = {shift_q, sdaLine};
              rxValid_d = 1'b1;
              ninth_d   = 1'b0;
              state_d   = RX_ACK;
            end
          end
        end
        TX_BYTE: begin
          if (sclRise) begin
            bitCnt_d = bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) ninth_d = 1'b1;
          end else if (sclFall) begin
            if (ninth_q) begin
              sdaOe_d = 1'b0;
              ninth_d = 1'b0;
              state_d = TX_ACK;
            end else begin
              sdaOe_d = ~shift_q[6];
              shift_d = {shift_q[5:0], 1'b0};
            end
          end
        end
        TX_ACK: begin
          if (sclRise && !ninth_q) begin
            if (!sdaLine) begin
              txReq_d = 1'b1;
              ninth_d = 1'b1;
            end else begin
              state_d   = IDLE;
              addrHit_d = 1'b0;
            end
          end else if (sclFall && ninth_q) begin
            ninth_d  = 1'b0;
            bitCnt_d = 3'd0;
            shift_d  = tx_data[6:0];
            sdaOe_d  = ~tx_data[7];
            state_d  = TX_BYTE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs come straight from registers so SDA is glitch-free and resets at once.
  always_comb begin
    sda_oe   = sdaOe_q;
    rx_data  = rxData_q;
    rx_valid = rxValid_q;
    tx_req   = txReq_q;
    addr_hit = addrHit_q;
    busy     = busy_q;
  end

endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bus-level I2C master driving i2c_slave, with a scoreboard
// monitor for rx_valid / tx_req and a transaction-level reference model.
module tb_i2c_slave;

  localparam int Q = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic       masterScl = 1'b1;
  logic       masterSda = 1'b1;
  logic       sclBus, sdaBus;
  logic       sda_oe, rx_valid, tx_req, addr_hit, busy;
  logic [7:0] rx_data;
  logic [7:0] tx_data = 8'h00;

  int         checkCount = 0;
  int         passCount  = 0;
  int         oeCycles   = 0;
  logic [7:0] expRx[$];
  int         expTxReq[$];
  logic [7:0] payload[0:3];

  assign sclBus = masterScl;
  assign sdaBus = masterSda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .scl_in  (sclBus),
    .sda_in  (sdaBus),
    .sda_oe  (sda_oe),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_data (tx_data),
    .tx_req  (tx_req),
    .addr_hit(addr_hit),
    .busy    (busy)
  );

  // Compare one observed value against the model's expectation.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Scoreboard monitor: every DUT pulse must match a queued expectation.
  always @(negedge clk) begin
    if (sda_oe === 1'b1) oeCycles++;
    if (rx_valid !== 1'b0) begin
      checkOutput("rx_valid pending", 32'(expRx.size() != 0), 32'd1);
      if (expRx.size() != 0) checkOutput("rx_data", 32'(rx_data), 32'(expRx.pop_front()));
    end
    if (tx_req !== 1'b0) begin
      checkOutput("tx_req pending", 32'(expTxReq.size() != 0), 32'd1);
      if (expTxReq.size() != 0) void'(expTxReq.pop_front());
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic busStart();
    masterSda = 1'b1; waitClk(Q);
    masterScl = 1'b1; waitClk(Q);
    masterSda = 1'b0; waitClk(Q);
    masterScl = 1'b0; waitClk(Q);
  endtask

  task automatic busStop();
    masterSda = 1'b0; waitClk(Q);
    masterScl = 1'b1; waitClk(Q);
    masterSda = 1'b1; waitClk(2 * Q);
  endtask

  task automatic sendBit(input logic b);
    masterSda = b;    waitClk(Q);
    masterScl = 1'b1; waitClk(2 * Q);
    masterScl = 1'b0; waitClk(Q);
  endtask

  task automatic recvBit(output logic b);
    masterSda = 1'b1; waitClk(Q);
    masterScl = 1'b1; waitClk(Q);
    b = sdaBus;       waitClk(Q);
    masterScl = 1'b0; waitClk(Q);
  endtask

  task automatic writeByte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) sendBit(d[i]);
    recvBit(ack);
  endtask

  task automatic readByte(output logic [7:0] d, input logic [7:0] nextTx, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recvBit(b);
      d[i] = b;
    end
    tx_data = nextTx;
    sendBit(nack);
  endtask

  // One transfer: address phase, then n data bytes written or read.
  // Model: only SLAVE_ADDR is acknowledged; writes are all ACKed and
  // reported once each; reads deliver the supplied bytes, one tx_req per byte.
  task automatic applyStimulus(input logic [6:0] addr, input logic isRead, input int n, input logic withStop);
    logic       hit, ack;
    logic [7:0] got, nextTx;
    int         oeBefore;
    hit = (addr == 7'h50);
    busStart();
    if (isRead) tx_data = payload[0];
    if (hit && isRead) for (int i = 0; i < n; i++) expTxReq.push_back(i);
    oeBefore = oeCycles;
    writeByte({addr, isRead}, ack);
    checkOutput("address ack", 32'(ack), 32'(!hit));
    checkOutput("addr_hit after address", 32'(addr_hit), 32'(hit));
    checkOutput("busy after address", 32'(busy), 32'd1);
    if (!hit) begin
      checkOutput("sda never driven", 32'(oeCycles - oeBefore), 32'd0);
    end else if (!isRead) begin
      for (int i = 0; i < n; i++) begin
        expRx.push_back(payload[i]);
        writeByte(payload[i], ack);
        checkOutput("data ack", 32'(ack), 32'd0);
      end
    end else begin
      for (int i = 0; i < n; i++) begin
        nextTx = (i + 1 < n) ? payload[i + 1] : 8'h00;
        readByte(got, nextTx, (i == n - 1));
        checkOutput("read byte", 32'(got), 32'(payload[i]));
      end
      checkOutput("addr_hit after NACK", 32'(addr_hit), 32'd0);
      checkOutput("sda released after NACK", 32'(sda_oe), 32'd0);
    end
    if (withStop) begin
      busStop();
      checkOutput("busy after stop", 32'(busy), 32'd0);
      checkOutput("addr_hit after stop", 32'(addr_hit), 32'd0);
      checkOutput("rx_valid count", 32'(expRx.size()), 32'd0);
      checkOutput("tx_req count", 32'(expTxReq.size()), 32'd0);
    end
  endtask

  // Reset asserted while the target drives TX bit 4 low.
  task automatic resetDuringTx();
    logic ack, b;
    payload[0] = 8'h00;
    tx_data    = 8'h00;
    busStart();
    expTxReq.push_back(0);
    writeByte({7'h50, 1'b1}, ack);
    checkOutput("reset test address ack", 32'(ack), 32'd0);
    for (int i = 0; i < 3; i++) recvBit(b);
    masterSda = 1'b1; waitClk(Q);
    masterScl = 1'b1; waitClk(Q / 2);
    checkOutput("sda_oe before reset", 32'(sda_oe), 32'd1);
    #3 rst = 1'b0;
    #1;
    checkOutput("sda_oe at reset", 32'(sda_oe), 32'd0);
    checkOutput("rx_data at reset", 32'(rx_data), 32'h00);
    checkOutput("addr_hit at reset", 32'(addr_hit), 32'd0);
    checkOutput("busy at reset", 32'(busy), 32'd0);
    checkOutput("tx_req at reset", 32'(tx_req), 32'd0);
    checkOutput("rx_valid at reset", 32'(rx_valid), 32'd0);
    expTxReq.delete();
    waitClk(4);
    rst = 1'b1;
    masterScl = 1'b0; waitClk(Q);
    busStop();
    checkOutput("busy after reset recovery", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [6:0] a;
    logic       rd;
    int         n;
    rst = 1'b1;
    #2 rst = 1'b0;
    waitClk(4);
    checkOutput("reset sda_oe", 32'(sda_oe), 32'd0);
    checkOutput("reset rx_data", 32'(rx_data), 32'h00);
    checkOutput("reset rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("reset tx_req", 32'(tx_req), 32'd0);
    checkOutput("reset addr_hit", 32'(addr_hit), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    rst = 1'b1;
    waitClk(Q);

    $display("[TB] write 0x50 <- A5");
    payload[0] = 8'hA5;
    applyStimulus(7'h50, 1'b0, 1, 1'b1);

    $display("[TB] read 0x50 -> 3C with NACK");
    payload[0] = 8'h3C;
    applyStimulus(7'h50, 1'b1, 1, 1'b1);

    $display("[TB] address 0x51 ignored");
    applyStimulus(7'h51, 1'b0, 1, 1'b1);

    $display("[TB] write 11, repeated start, read 22 33");
    payload[0] = 8'h11;
    applyStimulus(7'h50, 1'b0, 1, 1'b0);
    payload[0] = 8'h22;
    payload[1] = 8'h33;
    applyStimulus(7'h50, 1'b1, 2, 1'b1);

    $display("[TB] reset during TX bit 4");
    resetDuringTx();

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    $display("[TB] one-clk SDA glitch in idle");
    waitClk(Q);
    @(posedge clk); #2 masterSda = 1'b0;
    @(posedge clk); #2 masterSda = 1'b1;
    waitClk(Q);
    checkOutput("busy after glitch", 32'(busy), 32'd0);
`endif

    $display("[TB] randomized transfers");
    for (int t = 0; t < 16; t++) begin
      a  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'h50;
      rd = 1'($urandom_range(0, 1));
      n  = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) payload[i] = 8'($urandom);
      applyStimulus(a, rd, n, 1'b1);
    end

    waitClk(Q);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
